// File: rtl/quantser_pkg.sv
// Shared types and helpers for the quantized bit-serial datapath.
package quantser_pkg;

  // Widest word the extension helper handles; the instantiating module
  // zero-pads into it and truncates back out of it.
  localparam int unsigned SEXT_W  = 64;
  localparam int unsigned SEXT_BW = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Keep the low nb+1 bits of word; replicate bit nb above them when sx is set.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0]  word,
                                             input logic [SEXT_BW-1:0] nb,
                                             input logic               sx);
    logic [SEXT_W-1:0] mask;
    logic [SEXT_W-1:0] res;
    mask = (SEXT_W'(1) << ({1'b0, nb} + 7'd1)) - SEXT_W'(1);
    res  = word & mask;
    if (sx && word[nb]) res = res | ~mask;
    return res;
  endfunction

  // Legal parameter combination: precision fits the output and the helper.
  function automatic bit params_ok(input int unsigned bdout, input int unsigned bdmax);
    return (bdmax >= 2) && (bdmax <= bdout) && (bdout <= SEXT_W);
  endfunction

endpackage

// File: rtl/quantdeser.sv
// Bit-serial (MSB first, variable precision) to parallel deserializer with
// sign/zero extension and a valid/ready output register.
module quantdeser
  import quantser_pkg::*;
#(
  parameter int unsigned BDOUT = 32,
  parameter int unsigned BDMAX = 32
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [$clog2(BDMAX)-1:0] bdin,
  input  logic                     signext,
  input  logic                     start,
  input  logic                     din,
  output logic                     busy,
  output logic [BDOUT-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     ovf
);

  localparam int unsigned BDW = $clog2(BDMAX);

  if (!params_ok(BDOUT, BDMAX)) begin : g_param_err
    $error("quantdeser: need 2 <= BDMAX <= BDOUT <= 64");
  end

  state_t           state;
  logic [BDMAX-1:0] acc;
  logic [BDW-1:0]   cnt;
  logic [BDW-1:0]   nb;
  logic             sx;

  logic [BDMAX-1:0] shifted;
  logic [BDMAX-1:0] cap_word;
  logic [BDW-1:0]   cap_nb;
  logic             cap_sx;
  logic             done;

  // Word assembled this cycle and whether it completes; a 1-bit word completes
  // straight out of IDLE using the live bdin/signext.
  always_comb begin
    shifted  = (acc << 1) | BDMAX'(din);
    cap_word = shifted;
    cap_nb   = nb;
    cap_sx   = sx;
    done     = 1'b0;
    if (state == IDLE) begin
      cap_word = BDMAX'(din);
      cap_nb   = bdin;
      cap_sx   = signext;
      done     = start && (bdin == '0);
    end else begin
      done     = (cnt == BDW'(1));
    end
  end

  // Capture FSM plus output register; completions are never stalled.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      nb         <= '0;
      sx         <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= BDMAX'(din);
            cnt <= bdin;
            nb  <= bdin;
            sx  <= signext;
            if (bdin != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= shifted;
          cnt <= cnt - BDW'(1);
          if (cnt == BDW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (done) begin
        dout       <= BDOUT'(sext(SEXT_W'(cap_word), SEXT_BW'(cap_nb), cap_sx));
        dout_valid <= 1'b1;
        if (dout_valid && !dout_ready) ovf <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quantdeser.sv
// Self-checking bench for quantdeser (BDOUT=32, BDMAX=16).
module tb_quantdeser;

  logic        clk;
  logic        clr_n;
  logic [3:0]  bdin;
  logic        signext;
  logic        start;
  logic        din;
  logic        busy;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        ovf;

  quantdeser #(.BDOUT(32), .BDMAX(16)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .bdin       (bdin),
    .signext    (signext),
    .start      (start),
    .din        (din),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural reference: collects bits as an integer, extends arithmetically.
  bit          m_act;
  longint      m_bits;
  int          m_len;
  int          m_got;
  bit          m_sx;
  logic [31:0] m_dout;
  bit          m_v;
  bit          m_ovf;

  logic [31:0] rx_q[$];   // words the DUT handed over
  logic [31:0] mx_q[$];   // words the model expects handed over

  function automatic logic [31:0] ext(input longint v, input int n, input bit sx_i);
    longint r;
    r = v;
    if (sx_i && (((v >> (n - 1)) & 64'sd1) != 0)) r = v - (64'sd1 << n);
    return 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_bits = 0; m_len = 0; m_got = 0; m_sx = 0;
    m_dout = '0; m_v = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input logic s, input logic d, input logic [3:0] b,
                            input logic x, input logic rdy, input logic rst);
    bit done;
    done = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      if (s) begin
        m_bits = longint'(d);
        m_len  = int'(b) + 1;
        m_sx   = x;
        m_got  = 1;
        if (m_len == 1) done = 1;
        else m_act = 1;
      end
    end else begin
      m_bits = m_bits * 2 + longint'(d);
      m_got++;
      if (m_got == m_len) begin
        done  = 1;
        m_act = 0;
      end
    end
    if (done) begin
      if (m_v && !rdy) m_ovf = 1;
      m_dout = ext(m_bits, m_len, m_sx);
      m_v    = 1;
    end else if (m_v && rdy) begin
      m_v = 0;
    end
  endtask

  // One clock: drive, record handshakes, clock, update model, compare.
  task automatic step(input logic s, input logic d, input logic [3:0] b,
                      input logic x, input logic rdy, input logic rst);
    start = s; din = d; bdin = b; signext = x; dout_ready = rdy; clr_n = rst;
    if (rst && dout_valid && rdy) rx_q.push_back(dout);
    if (rst && m_v && rdy)        mx_q.push_back(m_dout);
    @(posedge clk);
    model_edge(s, d, b, x, rdy, rst);
    #1;
    chk("dout",       dout,              m_dout);
    chk("dout_valid", 32'(dout_valid),   32'(m_v));
    chk("busy",       32'(busy),         32'(m_act));
    chk("ovf",        32'(ovf),          32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), rdy, 1'b1);
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready only on last bit, 3 random.
  task automatic send_word(input int len, input logic [31:0] val, input bit sx_i,
                           input int rmode, input bit noise);
    for (int i = 0; i < len; i++) begin
      logic s;
      logic [3:0] b;
      logic x;
      logic r;
      s = (i == 0) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      b = (i == 0) ? 4'(len - 1) : 4'($urandom);
      x = (i == 0) ? sx_i : 1'($urandom);
      case (rmode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = (i == len - 1);
        default: r = 1'($urandom);
      endcase
      step(s, val[len-1-i], b, x, r, 1'b1);
    end
  endtask

  int base;

  initial begin
    model_reset();
    start = 0; din = 0; bdin = '0; signext = 0; dout_ready = 0; clr_n = 0;

    // Reset state
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_dout", dout, 32'h0);
    idle(2, 1'b1);

    // 4-bit 1011, sign- then zero-extended, back to back
    send_word(4, 32'hB, 1'b1, 1, 1'b0);
    chk("s4_sext", dout, 32'hFFFF_FFFB);
    chk("s4_valid", 32'(dout_valid), 32'd1);
    send_word(4, 32'hB, 1'b0, 1, 1'b0);
    chk("s4_zext", dout, 32'h0000_000B);

    // Single-bit words
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("b1_one", dout, 32'hFFFF_FFFF);
    chk("b1_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("b1_zero", dout, 32'h0);
    idle(1, 1'b1);

    // Overwrite of an unconsumed word
    send_word(8, 32'h5A, 1'b0, 0, 1'b0);
    send_word(8, 32'hC3, 1'b0, 0, 1'b0);
    chk("ovw_dout", dout, 32'h0000_00C3);
    chk("ovw_ovf", 32'(ovf), 32'd1);

    // Reset mid-capture, then full-precision word
    step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_dout", dout, 32'h0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    send_word(16, 32'h8001, 1'b1, 1, 1'b0);
    chk("w16_sext", dout, 32'hFFFF_8001);
    idle(1, 1'b1);

    // Transfer of the old word coinciding with the next completion
    base = rx_q.size();
    send_word(8, 32'h5A, 1'b0, 0, 1'b0);
    send_word(8, 32'hC3, 1'b0, 2, 1'b0);
    chk("xfer_dout", dout, 32'h0000_00C3);
    chk("xfer_ovf", 32'(ovf), 32'd0);
    idle(1, 1'b1);
    chk("xfer_cnt", 32'(rx_q.size() - base), 32'd2);
    if (rx_q.size() >= base + 2) begin
      chk("xfer_first", rx_q[base], 32'h0000_005A);
      chk("xfer_second", rx_q[base+1], 32'h0000_00C3);
    end

    // start re-pulsed mid-word with other bdin/signext values
    send_word(8, 32'hA7, 1'b1, 1, 1'b1);
    chk("noise_sext", dout, 32'hFFFF_FFA7);
    idle(1, 1'b1);

    // Randomized words, gaps, backpressure and stray starts
    for (int w = 0; w < 60; w++) begin
      int len;
      len = int'($urandom_range(1, 16));
      send_word(len, $urandom, 1'($urandom), 3, 1'b1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom));
    end
    idle(2, 1'b1);

    // Every handed-over word matches the model's sequence
    chk("rx_count", 32'(rx_q.size()), 32'(mx_q.size()));
    for (int i = 0; i < rx_q.size() && i < mx_q.size(); i++) chk("rx_word", rx_q[i], mx_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
